// File: rtl/aes_spi_pkg.sv
// Shared constants and FSM state type for the SPI slave that feeds the AES core.
package aes_spi_pkg;
   localparam int WORD_W_DEFAULT = 128;
   localparam bit SPI_CPOL       = 1'b0;
   localparam bit SPI_CPHA       = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;
endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin, followed by registered edge pulses.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= RST_VAL;
         q    <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= d;
         q    <= s1;
         rise <= s1 & ~q;
         fall <= ~s1 & q;
      end
   end
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: one WORD_W-bit frame per cs_n window in, core result word out on miso.
//
// state  | meaning
// IDLE   | cs_n high (or not yet seen falling); miso held 0
// ACTIVE | frame in progress, sampling mosi and shifting miso
// DONE   | WORD_W bits received; extra sample edges mark the frame too long
module spi_slave
   import aes_spi_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              frame_err,
   output logic              overrun
);
   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
   logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .d(sclk),
      .q(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync #(.RST_VAL(1'b0)) u_sync_cs (
      .clk(clk), .reset(reset), .d(cs_n),
      .q(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall));

   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(mosi),
      .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   logic cap_edge, launch_edge;
   assign cap_edge    = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
   assign launch_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] rx_shift;
   logic [WORD_W-1:0] tx_shift;
   logic [WORD_W-1:0] tx_hold;
   logic              too_long;

   assign miso = (state != IDLE) && tx_shift[WORD_W-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         tx_hold   <= '0;
         too_long  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_ready  <= 1'b1;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         if (tx_valid && tx_ready) begin
            tx_hold  <= tx_data;
            tx_ready <= 1'b0;
         end
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= ACTIVE;
                  bit_cnt  <= '0;
                  too_long <= 1'b0;
                  if (!tx_ready) begin
                     tx_shift <= tx_hold;
                     tx_ready <= 1'b1;
                  end else begin
                     tx_shift <= '0;
                  end
               end
            end
            ACTIVE, DONE: begin
               if (cs_rise) begin
                  state <= IDLE;
                  if (bit_cnt == CNT_MAX && !too_long) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (cap_edge) begin
                  if (state == ACTIVE) begin
                     rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
                     if (bit_cnt != CNT_MAX)
                        bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_MAX - 1'b1)
                        state <= DONE;
                  end else begin
                     // The trailing launch edge after the last bit is normal; only
                     // an extra sample edge means the master clocked too many bits.
                     too_long <= 1'b1;
                  end
               end else if (launch_edge && state == ACTIVE) begin
                  tx_shift <= tx_shift << 1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: an SPI master task plus a frame-level model of the slave.
module tb_spi_slave;
   localparam int W = 128;

   logic         clk, reset, sclk, cs_n, mosi, miso;
   logic [W-1:0] rx_data, tx_data;
   logic         rx_valid, rx_ready, tx_valid, tx_ready, frame_err, overrun;

   spi_slave #(.WORD_W(W)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .frame_err(frame_err), .overrun(overrun));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Frame-level model of what the slave must show once a frame has settled
   logic [W-1:0] m_rx_data = '0;
   logic         m_rx_valid = 1'b0;
   logic         m_tx_ready = 1'b1;
   logic [W-1:0] m_hold = '0;
   int           exp_ferr = 0, exp_ovr = 0;
   logic [W-1:0] exp_acc[$];

   // Observed events
   int           ferr_cnt = 0, ovr_cnt = 0;
   logic [W-1:0] got_acc[$];
   logic [W-1:0] last_acc = '0;
   logic         settled = 1'b0;

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (rx_valid && rx_ready) begin
         got_acc.push_back(rx_data);
         last_acc = rx_data;
      end
      if (settled && !reset) begin
         chk("rx_valid", W'(rx_valid), W'(m_rx_valid));
         chk("rx_data", rx_data, m_rx_data);
         chk("tx_ready", W'(tx_ready), W'(m_tx_ready));
         chk("miso_idle", W'(miso), W'(0));
         chk("frame_err_idle", W'(frame_err), W'(0));
         chk("overrun_idle", W'(overrun), W'(0));
      end
   end

   task automatic check_events();
      chk("frame_err_count", W'(ferr_cnt), W'(exp_ferr));
      chk("overrun_count", W'(ovr_cnt), W'(exp_ovr));
      chk("accept_count", W'(got_acc.size()), W'(exp_acc.size()));
      while (got_acc.size() > 0 && exp_acc.size() > 0)
         chk("accepted_word", got_acc.pop_front(), exp_acc.pop_front());
      got_acc.delete();
      exp_acc.delete();
   endtask

   task automatic write_tx(input logic [W-1:0] d);
      settled = 1'b0;
      @(posedge clk); #1;
      tx_data = d; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      m_hold = d; m_tx_ready = 1'b0;
      settled = 1'b1;
   endtask

   task automatic consume();
      settled = 1'b0;
      rx_ready = 1'b1;
      if (m_rx_valid) begin
         exp_acc.push_back(m_rx_data);
         m_rx_valid = 1'b0;
      end
      repeat (4) @(posedge clk); #1;
      settled = 1'b1;
      check_events();
   endtask

   // Master: nbits sample edges, MSB first; reset_after>0 pulses reset after that many bits
   task automatic send_frame(input logic [W-1:0] data, input int nbits, input int reset_after,
                             output logic [W-1:0] cap);
      logic [W-1:0] exp_miso;
      logic         b;
      bit           aborted;
      aborted = 0;
      cap = '0;
      settled = 1'b0;
      exp_miso = m_tx_ready ? '0 : m_hold;
      m_tx_ready = 1'b1;
      @(posedge clk); #2;
      cs_n = 1'b0;
      #60;
      for (int i = 0; i < nbits; i++) begin
         b = (i < W) ? data[W-1-i] : 1'b0;
         mosi = b;
         #50 sclk = 1'b1;
         cap = {cap[W-2:0], miso};
         #50 sclk = 1'b0;
         if (reset_after > 0 && i + 1 == reset_after) begin
            reset = 1'b1;
            #40 reset = 1'b0;
            aborted = 1;
            m_rx_data = '0; m_rx_valid = 1'b0; m_tx_ready = 1'b1; m_hold = '0;
         end
      end
      #60 cs_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      if (!aborted) begin
         if (nbits == W) begin
            if (!m_rx_valid || rx_ready) begin
               m_rx_data = data;
               if (rx_ready) exp_acc.push_back(data);
               else m_rx_valid = 1'b1;
            end else begin
               exp_ovr++;
            end
            chk("miso_word", cap, exp_miso);
         end else begin
            exp_ferr++;
         end
      end
      settled = 1'b1;
      check_events();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   localparam logic [W-1:0] A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [W-1:0] T = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
   localparam logic [W-1:0] B = 128'hA5A5A5A5_00000001_80000000_FFFF0000;
   localparam logic [W-1:0] C = 128'h0F0F0F0F_12345678_9ABCDEF0_13579BDF;
   localparam logic [W-1:0] D = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
   localparam logic [W-1:0] E = 128'hCAFEBABE_DEADBEEF_0BADF00D_FEEDFACE;

   logic [W-1:0] cap;

   initial begin
      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0;
      repeat (4) @(posedge clk); #1;
      chk("reset_rx_valid", W'(rx_valid), W'(0));
      chk("reset_rx_data", rx_data, '0);
      chk("reset_tx_ready", W'(tx_ready), W'(1));
      chk("reset_miso", W'(miso), W'(0));
      chk("reset_frame_err", W'(frame_err), W'(0));
      chk("reset_overrun", W'(overrun), W'(0));
      reset = 1'b0;
      repeat (6) @(posedge clk); #1;
      settled = 1'b1;

      // Good frame, consumed immediately
      send_frame(A, W, 0, cap);
      chk("good_frame_word", last_acc, A);
      chk("good_frame_miso_zero", cap, '0);
      chk("good_frame_no_err", W'(ferr_cnt), W'(0));

      // Loopback of a preloaded result word
      write_tx(T);
      chk("tx_ready_after_write", W'(tx_ready), W'(0));
      send_frame(~T, W, 0, cap);
      chk("loopback_word", cap, T);
      chk("loopback_tx_ready", W'(tx_ready), W'(1));
      chk("loopback_rx_word", last_acc, ~T);

      // Short and long frames
      send_frame(B, W - 1, 0, cap);
      chk("short_frame_err", W'(ferr_cnt), W'(1));
      chk("short_frame_rx_valid", W'(rx_valid), W'(0));
      send_frame(B, W + 1, 0, cap);
      chk("long_frame_err", W'(ferr_cnt), W'(2));
      chk("long_frame_rx_valid", W'(rx_valid), W'(0));

      // Overrun: first frame held, second dropped
      rx_ready = 1'b0;
      send_frame(B, W, 0, cap);
      chk("held_rx_valid", W'(rx_valid), W'(1));
      send_frame(C, W, 0, cap);
      chk("overrun_count_lit", W'(ovr_cnt), W'(1));
      chk("overrun_keeps_data", rx_data, B);
      consume();
      chk("overrun_consumed", last_acc, B);

      // Reset mid-frame, then a clean frame
      write_tx(C);
      send_frame(D, W, 60, cap);
      chk("abort_no_err", W'(ferr_cnt), W'(2));
      chk("abort_no_valid", W'(rx_valid), W'(0));
      chk("abort_tx_ready", W'(tx_ready), W'(1));
      send_frame(E, W, 0, cap);
      chk("post_reset_word", last_acc, E);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
